multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM datapath.
- Decodes the instruction register, evaluates condition codes against a held flags register, and steps the main FSM one state per cycle.
- Drives every datapath control input: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl.
- Sits beside the datapath inside the arm top level.

Parameters:
- STATE_W, 4, width of the exported FSM state.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- Instr  in  32  instruction register contents from the datapath.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- RegSrc  out  2  bit0: read R15 as Rn (branch); bit1: read Rd as RA2 (store).
- ALUSrcA  out  2  00=A register, 01=PC, 10=ALUOut.
- ALUSrcB  out  2  00=WriteData register, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (pass B).
- State  out  STATE_W  current FSM state, for debug and bench checks.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=15.
- Reset (asynchronous): State=FETCH, flags=0000, CondExReg=0. Every output takes its FETCH-state value as soon as reset is applied.
- Transitions:
  - FETCH -> DECODE.
  - DECODE routes on Op=Instr[27:26]:
    - 00 with I (Instr[25]) = 1 -> EXECUTEI.
    - 00 with I = 0 -> EXECUTER.
    - 01 -> MEMADR.
    - 10 -> BRANCH.
    - 11, or an illegal cmd -> UNKNOWN.
  - MEMADR -> MEMRD if L (Instr[20]) = 1, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
  - UNKNOWN is sticky until reset.
- Legal cmd values: AND=0000, EOR=0001, SUB=0010, ADD=0100, ORR=1100, MOV=1101, CMP=1010. CMP requires S=1 and implies NoWrite.
- Outputs per state (unlisted outputs are 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01. ALUControl=ADD if U (Instr[23]) = 1, else SUB.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExReg.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExReg.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl from cmd.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondExReg & ~NoWrite.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondExReg.
- Condition evaluation:
  - CondEx is evaluated in DECODE from Instr[31:28] against the flags register and latched into CondExReg at the end of DECODE. A flag update in EXECUTE therefore never affects the same instruction.
  - Codes 0000 through 1110 follow the ARM definitions (EQ through AL). 1111 evaluates false.
- Flag update, at the end of EXECUTER or EXECUTEI, only if S (Instr[20]) = 1 and CondExReg = 1:
  - N and Z always update.
  - C and V update only for ADD, SUB and CMP.
- RegSrc and ImmSrc are combinational from Instr in every state.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - state encodings;
  - ALUControl codes;
  - ALUSrcA, ALUSrcB and ResultSrc select constants;
  - cmd opcodes;
  - condition codes.
- One sub-module, cond_unit: the flags register, condition check, CondExReg and flag-write gating. The top level keeps the FSM and decoder.

Test Plan:
- ADD R2,R0,#5 (E2802005) -> states 0,1,7,8,0. ALUControl=000 and ALUSrcB=01 in EXECUTEI. RegWrite=1 only in ALUWB.
- LDR R1,[R0,#4] (E5901004) -> states 0,1,2,3,4. AdrSrc=1 in MEMRD. RegWrite=1 with ResultSrc=01 in MEMWB. STR (E5801004) -> states 0,1,2,5, with MemWrite=1 only in MEMWR and RegSrc=10.
- CMP R0,#0 (E3500000) with ALUFlags=0100 in EXECUTEI -> RegWrite=0 in ALUWB. Then BEQ (0A000002) -> PCWrite=1 in BRANCH. Repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
- ADDNE (12802005) with Z=1 held -> passes through ALUWB with RegWrite=0. Flags stay unchanged even if S=1.
- Instr=EC000000 (Op=11) -> UNKNOWN reached after DECODE. All write enables stay 0 for 10 cycles. Reset -> FETCH.
- Reset asserted asynchronously mid-MEMRD -> State=0 and flags=0 immediately, before the next edge. IRWrite=1 and PCWrite=1 on the first cycle after release.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, data-processing opcodes and condition codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd15
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags are packed {N,Z,C,V}; the 1111 code falls to the default and never executes
  function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: condCheck = z;
      COND_NE: condCheck = ~z;
      COND_CS: condCheck = c;
      COND_CC: condCheck = ~c;
      COND_MI: condCheck = n;
      COND_PL: condCheck = ~n;
      COND_VS: condCheck = v;
      COND_VC: condCheck = ~v;
      COND_HI: condCheck = c & ~z;
      COND_LS: condCheck = ~c | z;
      COND_GE: condCheck = (n == v);
      COND_LT: condCheck = (n != v);
      COND_GT: condCheck = ~z & (n == v);
      COND_LE: condCheck = z | (n != v);
      COND_AL: condCheck = 1'b1;
      default: condCheck = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Holds the NZCV flags and the latched condition result for the instruction
// currently in flight; flag writes are gated by that latched result.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] aluFlags_i,
  input  logic       decode_i,
  input  logic       execute_i,
  input  logic       setFlags_i,
  input  logic       updateCV_i,
  output logic       condExReg_o
);

  logic [3:0] flags_q, flags_d;
  logic       condExReg_q, condExReg_d;
  logic       flagWrite;

  // Condition is sampled against the flags as they stand in DECODE, so an
  // instruction's own flag update can never change whether it executes.
  always_comb begin
    flags_d     = flags_q;
    condExReg_d = condExReg_q;
    flagWrite   = execute_i & setFlags_i & condExReg_q;
    if (decode_i) begin
      condExReg_d = condCheck(cond_i, flags_q);
    end
    if (flagWrite) begin
      flags_d[3:2] = aluFlags_i[3:2];
      if (updateCV_i) begin
        flags_d[1:0] = aluFlags_i[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      condExReg_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      condExReg_q <= condExReg_d;
    end
  end

  assign condExReg_o = condExReg_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction decoder plus the main FSM that
// drives every datapath enable and select, one state per clock.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  state_e     state_q, state_d;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       immBit, sBit, uBit;
  logic       cmdLegal, noWrite, updateCV;
  logic [2:0] cmdAluCtrl;
  logic       condExReg;
  logic       unusedInstr;

  assign op          = Instr[27:26];
  assign immBit      = Instr[25];
  assign cmd         = Instr[24:21];
  assign uBit        = Instr[23];
  assign sBit        = Instr[20];
  assign noWrite     = (cmd == CMD_CMP);
  assign unusedInstr = ^{Instr[22], Instr[19:0]};

  // Bit 20 doubles as S for data processing and L for memory instructions.
  always_comb begin
    cmdLegal   = 1'b1;
    cmdAluCtrl = ALU_ADD;
    updateCV   = 1'b0;
    case (cmd)
      CMD_AND: cmdAluCtrl = ALU_AND;
      CMD_EOR: cmdAluCtrl = ALU_EOR;
      CMD_SUB: begin cmdAluCtrl = ALU_SUB; updateCV = 1'b1; end
      CMD_ADD: begin cmdAluCtrl = ALU_ADD; updateCV = 1'b1; end
      CMD_ORR: cmdAluCtrl = ALU_ORR;
      CMD_MOV: cmdAluCtrl = ALU_MOV;
      CMD_CMP: begin cmdAluCtrl = ALU_SUB; updateCV = 1'b1; cmdLegal = sBit; end
      default: cmdLegal = 1'b0;
    endcase
  end

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (Instr[31:28]),
    .aluFlags_i  (ALUFlags),
    .decode_i    (state_q == DECODE),
    .execute_i   ((state_q == EXECUTER) || (state_q == EXECUTEI)),
    .setFlags_i  (sBit),
    .updateCV_i  (updateCV),
    .condExReg_o (condExReg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   state_d = !cmdLegal ? UNKNOWN : (immBit ? EXECUTEI : EXECUTER);
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:                      state_d = sBit ? MEMRD : MEMWR;
      MEMRD:                       state_d = MEMWB;
      EXECUTER, EXECUTEI:          state_d = ALUWB;
      MEMWB, MEMWR, ALUWB, BRANCH: state_d = FETCH;
      default:                     state_d = UNKNOWN;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = uBit ? ALU_ADD : ALU_SUB;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = condExReg;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condExReg;
      end
      EXECUTER: ALUControl = cmdAluCtrl;
      EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = cmdAluCtrl;
      end
      ALUWB: RegWrite = condExReg & ~noWrite;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = condExReg;
      end
      default: ;
    endcase
  end

  assign RegSrc = {(op == OP_MEM) & ~sBit, (op == OP_BR)};
  assign ImmSrc = op;
  assign State  = STATE_W'(state_q);

endmodule
